// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between itcm and the execution stage.
// Tracks one in-flight itcm fetch and captures its response one cycle later
// with its PC. Captured {pc, inst} pairs sit in a DEPTH-entry circular buffer.
// Fetch credit (issue_ok) is granted only while every in-flight fetch is
// guaranteed a free slot. A redirect (flush) drops everything.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a response
// arriving at an empty queue is presented on out_* in the same cycle.
//
// Handshake: out_v/out_rdy follow strict valid/ready semantics. A transfer
// happens on a rising edge where out_v & out_rdy. out_v never depends on
// out_rdy. While out_v=1 and out_rdy=0 the head is held stable. On the request
// side, req_v is honoured only while issue_ok=1.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_v,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] inst_i,
  output logic            issue_ok,
  input  logic            flush,
  output logic            out_v,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  input  logic            out_rdy,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            pend_v;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] last_inst;

  logic            stored_v;
  logic            byp_v;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_inst;
  logic [AW+1:0]   occupancy;
  logic            req_acc;
  logic            push;
  logic            pop;

  // Head selection, credit and push/pop decode from registered state.
  always_comb begin
    stored_v  = (count != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_v     = pend_v & ~flush & ~stored_v;
`else
    byp_v     = 1'b0;
`endif
    head_pc   = stored_v ? pc_mem[rd_ptr]   : pend_pc;
    head_inst = stored_v ? inst_mem[rd_ptr] : inst_i;
    out_v     = (stored_v | byp_v) & ~flush;
    // When nothing is presented, the last presented pair is held.
    out_pc    = out_v ? head_pc   : last_pc;
    out_inst  = out_v ? head_inst : last_inst;
    // Credit counts the in-flight fetch as an already-claimed slot.
    occupancy = {1'b0, count} + {{(AW+1){1'b0}}, pend_v};
    issue_ok  = flush | (occupancy < DEPTH_W);
    req_acc   = req_v & issue_ok;
    pop       = out_v & out_rdy & stored_v;
    // A bypassed response that is consumed immediately never touches storage.
    push      = pend_v & ~flush & ~(byp_v & out_rdy);
    empty     = ~stored_v & ~pend_v;
  end

  // Queue state, in-flight tracking and held output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend_v    <= 1'b0;
      pend_pc   <= '0;
      last_pc   <= '0;
      last_inst <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      pend_v <= req_acc;
      if (req_acc) begin
        pend_pc <= req_pc;
      end
      if (out_v) begin
        last_pc   <= head_pc;
        last_inst <= head_inst;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]   <= pend_pc;
          inst_mem[wr_ptr] <= inst_i;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue (DEPTH=4, XLEN=32).
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        req_v;
  logic [31:0] req_pc;
  logic [31:0] inst_i;
  logic        issue_ok;
  logic        flush;
  logic        out_v;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_rdy;
  logic        empty;

  int          total;
  int          bad;
  int          pops;
  bit          last_out_v;
  logic [31:0] prev_pc;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_v    (req_v),
    .req_pc   (req_pc),
    .inst_i   (inst_i),
    .issue_ok (issue_ok),
    .flush    (flush),
    .out_v    (out_v),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .out_rdy  (out_rdy),
    .empty    (empty)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, let them settle, score any transfer, then
  // advance to 1 time unit after the next rising edge.
  task automatic run_cycle(input bit rv, input logic [31:0] pc, input bit rdy,
                           output bit accepted);
    req_v   = rv;
    req_pc  = pc;
    out_rdy = rdy;
    flush   = 1'b0;
    inst_i  = inst_of(prev_pc);
    #1;
    last_out_v = out_v;
    if (out_v && out_rdy) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("spurious_pop", 32'(out_v), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e);
        chk("pop_inst", out_inst, inst_of(e));
      end
    end
    accepted = rv && issue_ok;
    if (accepted) begin
      exp_q.push_back(pc);
      prev_pc = pc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          acc;
    int          n;
    logic [31:0] pc;
    total = 0; bad = 0; pops = 0; prev_pc = '0;
    reset = 1'b1; req_v = 1'b0; req_pc = '0; inst_i = '0; flush = 1'b0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    // Reset state.
    chk("rst_out_v", 32'(out_v), 32'd0);
    chk("rst_issue_ok", 32'(issue_ok), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    @(posedge clk);
    #1;

    // Single fetch of 0x100, consumer always ready.
    run_cycle(1'b1, 32'h100, 1'b1, acc);
    chk("single_acc", 32'(acc), 32'd1);
    chk("single_v_n", 32'(last_out_v), 32'd0);
    run_cycle(1'b0, 32'h0, 1'b1, acc);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("single_v_n1", 32'(last_out_v), 32'd1);
    run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("single_v_n2", 32'(last_out_v), 32'd0);
`else
    chk("single_v_n1", 32'(last_out_v), 32'd0);
    run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("single_v_n2", 32'(last_out_v), 32'd1);
`endif
    chk("single_pops", 32'(pops), 32'd1);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_hold_pc", out_pc, 32'h100);
    chk("single_hold_inst", out_inst, 32'h5A5A_0113);

    // Stall fill: out_rdy=0 with continuous requests from PC 0.
    pc = 32'h0; n = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b1, pc, 1'b0, acc);
      if (!acc) break;
      n++;
      pc += 32'd4;
    end
    chk("fill_accepted", 32'(n), 32'd4);
    req_v = 1'b0;
    #1;
    chk("fill_count", 32'(dut.count), 32'd4);
    chk("fill_issue_ok", 32'(issue_ok), 32'd0);
    chk("fill_head_pc", out_pc, 32'h0);
    chk("fill_head_v", 32'(out_v), 32'd1);
    run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("drain_credit", 32'(issue_ok), 32'd1);
    repeat (3) run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_out_v", 32'(out_v), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Flush with 3 queued and 1 in flight; redirect fetch 0x200 in the flush cycle.
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 32'h40 + 32'(i * 4), 1'b0, acc);
    chk("pre_flush_count", 32'(dut.count), 32'd3);
    chk("pre_flush_pend", 32'(dut.pend_v), 32'd1);
    req_v = 1'b1; req_pc = 32'h200; flush = 1'b1; out_rdy = 1'b1; inst_i = inst_of(32'h4C);
    #1;
    chk("flush_out_v", 32'(out_v), 32'd0);
    chk("flush_issue_ok", 32'(issue_ok), 32'd1);
    exp_q.delete();
    exp_q.push_back(32'h200);
    prev_pc = 32'h200;
    pops = 0;
    @(posedge clk);
    #1;
    chk("post_flush_count", 32'(dut.count), 32'd0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("flush_pops", 32'(pops), 32'd1);
    chk("flush_left", 32'(exp_q.size()), 32'd0);

    // Wrap-around: 10 fetches with out_rdy toggling every cycle.
    pc = 32'h500; n = 0; pops = 0;
    for (int i = 0; i < 80 && (n < 10 || exp_q.size() > 0); i++) begin
      run_cycle(n < 10, pc, i[0], acc);
      if (acc) begin
        n++;
        pc += 32'd4;
      end
    end
    chk("wrap_issued", 32'(n), 32'd10);
    chk("wrap_pops", 32'(pops), 32'd10);
    chk("wrap_left", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream with entries queued and a response arriving.
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 32'h300 + 32'(i * 4), 1'b0, acc);
    reset = 1'b1; req_v = 1'b0; out_rdy = 1'b0; inst_i = inst_of(32'h308);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_v", 32'(out_v), 32'd0);
    chk("mid_rst_count", 32'(dut.count), 32'd0);
    chk("mid_rst_issue_ok", 32'(issue_ok), 32'd1);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_out_pc", out_pc, 32'd0);
    exp_q.delete();
    pops = 0;
    repeat (3) run_cycle(1'b0, 32'h0, 1'b1, acc);
    chk("mid_rst_no_out", 32'(pops), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
